// File: rtl/opd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opd_pkg
//  Description : Shared types and constants for the operand dispatcher.
//                opcode_e doubles as the functional-unit channel index.
//  Revision    : 1.0  initial release
// ============================================================================
package opd_pkg;

    localparam int OPD_N        = 16;
    localparam int OPD_SEL_LINE = 4;
    localparam int OPD_NUM_CH   = 7;

    // Opcode value equals the target channel index
    typedef enum logic [OPD_SEL_LINE-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } opcode_e;

    typedef struct packed {
        logic [OPD_N-1:0] rs1;
        logic [OPD_N-1:0] rs2;
    } operand_pair_t;

endpackage : opd_pkg
`default_nettype wire

// File: rtl/opd_chan_slot.sv
`default_nettype none
// ============================================================================
//  Module      : opd_chan_slot
//  Description : One-entry valid/ready register slot. Accepts a load whenever
//                it is empty or being drained in the same cycle, giving full
//                one-per-cycle throughput. Data is held while stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module opd_chan_slot
    import opd_pkg::*;
#(
    parameter int W = 2 * OPD_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data_in,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data_out,
    output logic         can_load
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Slot state: load wins over drain so a simultaneous drain+fill stays valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= data_in;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign can_load = !r_valid || ready;
    assign valid    = r_valid;
    assign data_out = r_data;

endmodule : opd_chan_slot
`default_nettype wire

// File: rtl/rs_operand_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : rs_operand_dispatch
//  Description : Registered, handshaked operand dispatcher. Decodes the opcode
//                to one of NUM_CH channel slots, applies per-channel
//                back-pressure to in_ready and flags dropped illegal opcodes.
//                Optional macro OPD_PERF_CNT_EN adds per-channel dispatch
//                counters on disp_cnt (CNT_W bits each, wrapping).
//  Revision    : 1.0  initial release
// ============================================================================
module rs_operand_dispatch
    import opd_pkg::*;
#(
    parameter int N        = OPD_N,
    parameter int SEL_LINE = OPD_SEL_LINE,
    parameter int NUM_CH   = OPD_NUM_CH
`ifdef OPD_PERF_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_LINE-1:0]   in_opcode,
    input  logic [N-1:0]          in_rs1,
    input  logic [N-1:0]          in_rs2,
    output logic [NUM_CH-1:0]     out_valid,
    input  logic [NUM_CH-1:0]     out_ready,
    output logic [NUM_CH*N-1:0]   out_rs1,
    output logic [NUM_CH*N-1:0]   out_rs2,
    output logic                  bad_op,
    output logic                  busy
`ifdef OPD_PERF_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] disp_cnt
`endif
);

    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_can_load;
    logic [2*N-1:0]    w_slot_data [NUM_CH];
    logic              w_legal;
    logic              r_bad_op;

    // Opcode is legal exactly when it decodes to some channel
    assign w_legal  = |w_sel;
    assign in_ready = w_legal ? |(w_sel & w_can_load) : 1'b1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        localparam logic [SEL_LINE-1:0] c_IDX = SEL_LINE'(c);

        assign w_sel[c]  = (in_opcode == c_IDX);
        assign w_load[c] = in_valid && w_sel[c] && w_can_load[c];

        opd_chan_slot #(
            .W (2 * N)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (w_load[c]),
            .data_in  ({in_rs1, in_rs2}),
            .valid    (out_valid[c]),
            .ready    (out_ready[c]),
            .data_out (w_slot_data[c]),
            .can_load (w_can_load[c])
        );

        assign out_rs1[c*N +: N] = w_slot_data[c][2*N-1:N];
        assign out_rs2[c*N +: N] = w_slot_data[c][N-1:0];

`ifdef OPD_PERF_CNT_EN
        logic [CNT_W-1:0] r_cnt;

        // Count legal bundles accepted into this channel; wraps naturally
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_load[c]) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign disp_cnt[c*CNT_W +: CNT_W] = r_cnt;
`endif
    end

    // Illegal opcodes are always accepted, so in_valid alone marks a drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad_op <= 1'b0;
        end else begin
            r_bad_op <= in_valid && !w_legal;
        end
    end

    assign bad_op = r_bad_op;
    assign busy   = |out_valid;

endmodule : rs_operand_dispatch
`default_nettype wire

// File: tb/tb_rs_operand_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_operand_dispatch
//  Description : Self-checking bench for rs_operand_dispatch: table of
//                single-cycle vectors plus hand-written multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_operand_dispatch;
    import opd_pkg::*;

    localparam int N  = 16;
    localparam int NC = 7;
`ifdef OPD_PERF_CNT_EN
    localparam int CW = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [N-1:0]      in_rs1;
    logic [N-1:0]      in_rs2;
    logic [NC-1:0]     out_valid;
    logic [NC-1:0]     out_ready;
    logic [NC*N-1:0]   out_rs1;
    logic [NC*N-1:0]   out_rs2;
    logic              bad_op;
    logic              busy;
`ifdef OPD_PERF_CNT_EN
    logic [NC*CW-1:0]  disp_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rs_operand_dispatch #(
        .N        (N),
        .SEL_LINE (4),
        .NUM_CH   (NC)
`ifdef OPD_PERF_CNT_EN
        ,
        .CNT_W    (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .bad_op    (bad_op),
        .busy      (busy)
`ifdef OPD_PERF_CNT_EN
        ,
        .disp_cnt  (disp_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          v;
        logic [3:0]    op;
        logic [N-1:0]  rs1;
        logic [N-1:0]  rs2;
        logic [NC-1:0] ordy;
        logic          exp_rdy;
        logic [NC-1:0] exp_ov;
        logic          exp_bad;
        int            ch;
        logic [N-1:0]  exp_rs1;
        logic [N-1:0]  exp_rs2;
    } vec_t;

    vec_t vecs[15];

    // Drive at negedge, check in_ready before the edge and state after it
    task automatic drive(input logic v, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [NC-1:0] ordy);
        @(negedge clk);
        in_valid  = v;
        in_opcode = op;
        in_rs1    = a;
        in_rs2    = b;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = 4'd0;
        in_rs1 = '0; in_rs2 = '0; out_ready = '1;

        // Reset held two cycles
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset out_rs1", 128'(out_rs1), 128'(0));
        chk("reset out_rs2", 128'(out_rs2), 128'(0));
        chk("reset bad_op", 128'(bad_op), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(1));

        //          v     op      rs1       rs2       ordy          rdy   ov            bad   ch  ers1      ers2
        vecs[0]  = '{1'b1, OP_MUL, 16'h1234, 16'h00FF, 7'h7F,       1'b1, 7'b0000100, 1'b0, 2,  16'h1234, 16'h00FF};
        vecs[1]  = '{1'b0, OP_ADD, 16'h0,    16'h0,    7'h7F,       1'b1, 7'b0000000, 1'b0, 2,  16'h1234, 16'h00FF};
        vecs[2]  = '{1'b1, OP_ADD, 16'hAAAA, 16'h5555, 7'h7E,       1'b1, 7'b0000001, 1'b0, 0,  16'hAAAA, 16'h5555};
        vecs[3]  = '{1'b1, OP_ADD, 16'h1111, 16'h2222, 7'h7E,       1'b0, 7'b0000001, 1'b0, 0,  16'hAAAA, 16'h5555};
        vecs[4]  = '{1'b1, OP_ADD, 16'h1111, 16'h2222, 7'h7F,       1'b1, 7'b0000001, 1'b0, 0,  16'h1111, 16'h2222};
        vecs[5]  = '{1'b0, OP_ADD, 16'h0,    16'h0,    7'h7F,       1'b1, 7'b0000000, 1'b0, 0,  16'h1111, 16'h2222};
        vecs[6]  = '{1'b1, 4'd9,   16'hDEAD, 16'hBEEF, 7'h7F,       1'b1, 7'b0000000, 1'b1, -1, 16'h0,    16'h0};
        vecs[7]  = '{1'b0, OP_ADD, 16'h0,    16'h0,    7'h7F,       1'b1, 7'b0000000, 1'b0, -1, 16'h0,    16'h0};
        vecs[8]  = '{1'b1, OP_ADD, 16'h0101, 16'h0202, 7'h00,       1'b1, 7'b0000001, 1'b0, 0,  16'h0101, 16'h0202};
        vecs[9]  = '{1'b1, 4'd15,  16'hFFFF, 16'hFFFF, 7'h00,       1'b1, 7'b0000001, 1'b1, 0,  16'h0101, 16'h0202};
        vecs[10] = '{1'b1, 4'd7,   16'hEEEE, 16'hEEEE, 7'h00,       1'b1, 7'b0000001, 1'b1, 0,  16'h0101, 16'h0202};
        vecs[11] = '{1'b0, OP_ADD, 16'h0,    16'h0,    7'h00,       1'b0, 7'b0000001, 1'b0, 0,  16'h0101, 16'h0202};
        vecs[12] = '{1'b1, OP_SUB, 16'h3333, 16'h4444, 7'h00,       1'b1, 7'b0000011, 1'b0, 1,  16'h3333, 16'h4444};
        vecs[13] = '{1'b1, OP_AND, 16'h0005, 16'h0006, 7'b0000001,  1'b1, 7'b0010010, 1'b0, 4,  16'h0005, 16'h0006};
        vecs[14] = '{1'b0, OP_ADD, 16'h0,    16'h0,    7'h7F,       1'b1, 7'b0000000, 1'b0, 1,  16'h3333, 16'h4444};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].ordy);
            chk($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
            chk($sformatf("vec%0d bad_op", i), 128'(bad_op), 128'(vecs[i].exp_bad));
            chk($sformatf("vec%0d busy", i), 128'(busy), 128'(vecs[i].exp_ov != '0));
            if (vecs[i].ch >= 0) begin
                chk($sformatf("vec%0d rs1", i), 128'(out_rs1[vecs[i].ch*N +: N]), 128'(vecs[i].exp_rs1));
                chk($sformatf("vec%0d rs2", i), 128'(out_rs2[vecs[i].ch*N +: N]), 128'(vecs[i].exp_rs2));
            end
        end

        // Back-to-back XOR stream, one bundle per cycle into channel 6
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, OP_XOR, 16'h0A00 + 16'(k), 16'h0B00 + 16'(k), 7'h7F);
            chk($sformatf("xor%0d in_ready", k), 128'(in_ready), 128'(1));
            tick();
            chk($sformatf("xor%0d out_valid", k), 128'(out_valid), 128'(7'b1000000));
            chk($sformatf("xor%0d rs1", k), 128'(out_rs1[6*N +: N]), 128'(16'h0A00 + 16'(k)));
            chk($sformatf("xor%0d rs2", k), 128'(out_rs2[6*N +: N]), 128'(16'h0B00 + 16'(k)));
        end
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 7'h7F);
        tick();
        chk("xor drained", 128'(out_valid), 128'(0));

        // Fill AND and OR slots under stall, then reset mid-transfer
        drive(1'b1, OP_AND, 16'h4444, 16'h4445, 7'h00);
        tick();
        drive(1'b1, OP_OR, 16'h5555, 16'h5556, 7'h00);
        tick();
        chk("stall full", 128'(out_valid), 128'(7'b0110000));
        drive(1'b1, OP_AND, 16'h9999, 16'h9999, 7'h00);
        chk("stall and in_ready", 128'(in_ready), 128'(0));
        tick();
        chk("stall and hold", 128'(out_rs1[4*N +: N]), 128'(16'h4444));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("midrst out_valid", 128'(out_valid), 128'(0));
        chk("midrst out_rs1", 128'(out_rs1), 128'(0));
        chk("midrst out_rs2", 128'(out_rs2), 128'(0));
        chk("midrst busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst = 1'b0;

`ifdef OPD_PERF_CNT_EN
        // 17 SUB dispatches wrap a 4-bit counter back to 1
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, OP_SUB, 16'(k), 16'(k), 7'h7F);
            tick();
        end
        drive(1'b1, 4'd9, 16'h0, 16'h0, 7'h7F);
        tick();
        drive(1'b0, OP_ADD, 16'h0, 16'h0, 7'h7F);
        tick();
        chk("cnt sub wrap", 128'(disp_cnt[1*CW +: CW]), 128'(1));
        chk("cnt others", 128'(disp_cnt & ~(28'hF << CW)), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rs_operand_dispatch
`default_nettype wire
